// File: rtl/parallel_to_serial.sv
// -----------------------------------------------------------------------------
// parallel_to_serial
// Transmit-side shift register: accepts a WIDTH-bit word over a valid/ready
// handshake and shifts it out MSB first, one bit per clock, with frame
// activity and last-bit flags for gap-free back-to-back streaming.
// All state updates on the falling edge of clk; rst is synchronous,
// active-low.
// Optional feature: define PARITY_EN to append an even-parity bit to every
// frame (frame length WIDTH+1 clocks).
// -----------------------------------------------------------------------------
module parallel_to_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             tx_active,
    output logic             tx_last
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX     = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PRE_LAST_IDX = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
`ifdef PARITY_EN
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
`else
        ST_SHIFT  = 2'd1
`endif
    } state_t;

`ifdef PARITY_EN
    // Even parity over the whole accepted word.
    function automatic logic even_parity(input logic [WIDTH-1:0] word);
        return ^word;
    endfunction
`endif

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] shreg_r;
    logic [WIDTH-1:0] shreg_s;
    logic [CW-1:0]    bit_cnt_r;
    logic [CW-1:0]    bit_cnt_s;
    logic             serial_out_r;
    logic             serial_out_s;
    logic             tx_active_r;
    logic             tx_active_s;
    logic             tx_last_r;
    logic             tx_last_s;
    logic             load_ready_s;
    logic             accept_s;
    logic             last_bit_s;
`ifdef PARITY_EN
    logic             parity_r;
    logic             parity_s;
`endif

    assign accept_s   = load_valid & load_ready_s & rst;
    assign last_bit_s = (bit_cnt_r == LAST_IDX);

    // State register, falling edge, synchronous active-low reset.
    always_ff @(negedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: a frame ends either in idle or, on accept, in a fresh
    // SHIFT frame with no gap.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!last_bit_s) begin
                    state_s = ST_SHIFT;
                end else begin
`ifdef PARITY_EN
                    state_s = ST_PARITY;
`else
                    state_s = accept_s ? ST_SHIFT : ST_IDLE;
`endif
                end
            end
`ifdef PARITY_EN
            ST_PARITY: begin
                if (accept_s) begin
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output logic: load_ready opens in idle and in the final bit period of a
    // frame so the next word can follow without an idle gap.
    always_comb begin
        load_ready_s = 1'b0;
        if (!rst) begin
            load_ready_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE:   load_ready_s = 1'b1;
`ifdef PARITY_EN
                ST_SHIFT:  load_ready_s = 1'b0;
                ST_PARITY: load_ready_s = 1'b1;
`else
                ST_SHIFT:  load_ready_s = last_bit_s;
`endif
                default:   load_ready_s = 1'b0;
            endcase
        end
    end

    // Datapath next values: load on accept, otherwise shift, emit parity or
    // drop back to the idle line level.
    always_comb begin
        shreg_s      = shreg_r;
        bit_cnt_s    = bit_cnt_r;
        serial_out_s = serial_out_r;
        tx_active_s  = tx_active_r;
        tx_last_s    = tx_last_r;
`ifdef PARITY_EN
        parity_s     = parity_r;
`endif
        if (accept_s) begin
            shreg_s      = data_in;
            bit_cnt_s    = {CW{1'b0}};
            serial_out_s = data_in[WIDTH-1];
            tx_active_s  = 1'b1;
            tx_last_s    = 1'b0;
`ifdef PARITY_EN
            parity_s     = even_parity(data_in);
`endif
        end else begin
            case (state_r)
                ST_SHIFT: begin
                    if (!last_bit_s) begin
                        // Rotate so the next bit sits at the top; the bit
                        // wrapped into the LSB is never shown.
                        shreg_s      = {shreg_r[WIDTH-2:0], shreg_r[WIDTH-1]};
                        bit_cnt_s    = bit_cnt_r + {{(CW-1){1'b0}}, 1'b1};
                        serial_out_s = shreg_r[WIDTH-2];
                        tx_active_s  = 1'b1;
`ifdef PARITY_EN
                        tx_last_s    = 1'b0;
`else
                        tx_last_s    = (bit_cnt_r == PRE_LAST_IDX);
`endif
                    end else begin
`ifdef PARITY_EN
                        serial_out_s = parity_r;
                        tx_active_s  = 1'b1;
                        tx_last_s    = 1'b1;
`else
                        bit_cnt_s    = {CW{1'b0}};
                        serial_out_s = 1'b0;
                        tx_active_s  = 1'b0;
                        tx_last_s    = 1'b0;
`endif
                    end
                end
                default: begin
                    // Idle, or the parity bit just finished with no new word.
                    bit_cnt_s    = {CW{1'b0}};
                    serial_out_s = 1'b0;
                    tx_active_s  = 1'b0;
                    tx_last_s    = 1'b0;
                end
            endcase
        end
    end

    // Datapath and output registers, falling edge, synchronous reset.
    always_ff @(negedge clk) begin
        if (!rst) begin
            shreg_r      <= {WIDTH{1'b0}};
            bit_cnt_r    <= {CW{1'b0}};
            serial_out_r <= 1'b0;
            tx_active_r  <= 1'b0;
            tx_last_r    <= 1'b0;
`ifdef PARITY_EN
            parity_r     <= 1'b0;
`endif
        end else begin
            shreg_r      <= shreg_s;
            bit_cnt_r    <= bit_cnt_s;
            serial_out_r <= serial_out_s;
            tx_active_r  <= tx_active_s;
            tx_last_r    <= tx_last_s;
`ifdef PARITY_EN
            parity_r     <= parity_s;
`endif
        end
    end

    assign load_ready = load_ready_s;
    assign serial_out = serial_out_r;
    assign tx_active  = tx_active_r;
    assign tx_last    = tx_last_r;

endmodule

// File: doc/parallel_to_serial.md
Name: parallel_to_serial

Overview:
- Transmit-side counterpart of the team's `serial_to_parallel` 4-bit shift-register receiver.
- Accepts a parallel word through a valid/ready load handshake and shifts it out one bit per clock, MSB first.
- When `serial_out` drives the receiver's `serial_in`, the receiver's `parallel_out` equals the transmitted word after WIDTH bit periods.
- Provides frame activity and last-bit flags so upstream logic can stream words back-to-back with no idle gap.

Parameters:
- WIDTH, 4, data word width in bits; legal range is WIDTH >= 2.

Ports:
- clk  input  1  system clock; all state updates on the falling edge.
- rst  input  1  synchronous active-low reset, sampled on the clk falling edge.
- data_in  input  WIDTH  parallel word to transmit; sampled only on an accepting edge.
- load_valid  input  1  upstream has a word on data_in.
- load_ready  output  1  block can accept a word on this edge; combinational.
- serial_out  output  1  registered serial data, MSB first.
- tx_active  output  1  registered; high while a data or parity bit is on serial_out.
- tx_last  output  1  registered; high during the final bit period of a frame.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-low: rst low at a falling edge forces the following state.
  - state=IDLE, shreg=0, bit_cnt=0
  - serial_out=0, tx_active=0, tx_last=0
  - load_ready=0 while rst is low.
- Reset mid-frame: the frame is abandoned and the remaining bits are dropped. No partial-frame recovery.
- Accept condition: a word is accepted on a falling edge when load_valid && load_ready && rst.
- IDLE state:
  - load_ready=1, serial_out=0, tx_active=0.
  - On accept: serial_out<=data_in[WIDTH-1], shreg<=data_in, bit_cnt<=0, tx_active<=1, go to SHIFT.
  - Zero-cycle latency: the MSB is visible immediately after the accepting edge.
- SHIFT state: on each edge, bit_cnt<=bit_cnt+1 and serial_out<=shreg[WIDTH-2-bit_cnt].
  - Equivalent implementation: a left-shifting register whose top bit drives serial_out.
  - Each bit is held for exactly one clock.
  - bit_cnt width is clog2(WIDTH+1); it never wraps past WIDTH-1 in SHIFT.
  - tx_last=1 while bit WIDTH-1 (the LSB) is on serial_out, when parity is disabled.
- load_ready in SHIFT: high only in the last data-bit period, without PARITY_EN.
- End of frame, with accept in the last bit period: the new word's MSB follows the old LSB with no gap. Stay in SHIFT with bit_cnt<=0; tx_active stays 1.
- End of frame, without accept: go to IDLE; serial_out<=0, tx_active<=0, tx_last<=0.
- Held data: data_in changes outside accepting edges have no effect on the frame in flight.
- load_valid while not ready: ignored. The upstream must hold the word until accepted.

Optional Feature:
- Macro: PARITY_EN.
- Defined:
  - A PARITY state follows SHIFT, adding one extra bit period carrying even parity (XOR of all WIDTH bits of the accepted word). The frame is WIDTH+1 clocks.
  - tx_active=1 and tx_last=1 during the parity bit; tx_last=0 on the data LSB.
  - load_ready is high during the parity period (not the LSB period), so back-to-back words are separated only by their parity bit.
- Undefined: no PARITY state, no parity logic; behaviour as in Behaviour.

Test Plan:
- Reset: rst=0 for 2 edges with load_valid=1 -> serial_out=0, tx_active=0, tx_last=0, load_ready=0, nothing accepted. After rst=1 -> load_ready=1.
- Single word: data_in=4'b1011, one-cycle load_valid -> serial_out=1,0,1,1 on consecutive cycles; tx_last only on the 4th; then serial_out=0, tx_active=0, load_ready=1.
- Back-to-back: 4'hA then 4'h5, load_valid held -> serial_out=1,0,1,0,0,1,0,1 with no gap; tx_active continuously 1; load_ready high only in cycles 4 and 8.
- Busy/hold: load_valid=1 with data_in changed to 4'h0 mid-frame of 4'hC -> stream stays 1,1,0,0; 4'h0 accepted only at the last-bit edge.
- Reset mid-frame: after 2 bits of 4'hF, rst=0 for one edge -> serial_out=0, IDLE. Then send 4'h9 -> 1,0,0,1 complete. Loopback into serial_to_parallel yields parallel_out=4'h9 after 4 bits.
- PARITY_EN defined: 4'b1011 -> 1,0,1,1,1 with tx_last on the 5th bit; 4'b0110 -> 0,1,1,0,0.
